// File: rtl/ctrl_seq.sv
// Instruction sequencer: fetch/decode/execute FSM driving bus, register and ALU strobes.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap to HALT instead of running as NOP.
module ctrl_seq #(
    parameter int NUM_REGS = 4,
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        z,
    input  logic [5:0]  instr,
    output logic [2:0]  alu_op,
    output logic [3:0]  read_en,
    output logic [15:0] write_en,
    output logic [15:0] inc_en,
    output logic [15:0] clr_en,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_MWAIT, S_HALT
    } state_t;

    localparam logic [5:0] OP_LDAC   = 6'd3;
    localparam logic [5:0] OP_LDIAC  = 6'd5;
    localparam logic [5:0] OP_STAC   = 6'd8;
    localparam logic [5:0] OP_MVAC   = 6'd9;
    localparam logic [5:0] OP_MVACAR = 6'd10;
    localparam logic [5:0] OP_ADD    = 6'd19;
    localparam logic [5:0] OP_MULT   = 6'd20;
    localparam logic [5:0] OP_LSHIFT = 6'd21;
    localparam logic [5:0] OP_SUB    = 6'd22;
    localparam logic [5:0] OP_INAC   = 6'd23;
    localparam logic [5:0] OP_JPNZ   = 6'd24;
    localparam logic [5:0] OP_STIAC  = 6'd26;
    localparam logic [5:0] OP_JPZ    = 6'd27;
    localparam logic [5:0] OP_NOP    = 6'd28;
    localparam logic [5:0] OP_CLAC   = 6'd30;
    localparam logic [5:0] OP_END    = 6'd31;

    localparam logic [1:0] LAST = 2'(MEM_WAIT);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [1:0] cnt_q, cnt_d;
    logic       jmp_q, jmp_d;
    logic       ill_q, ill_d;

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LDAC, OP_LDIAC, OP_STAC, OP_STIAC, OP_MVAC, OP_MVACAR,
            OP_ADD, OP_MULT, OP_LSHIFT, OP_SUB, OP_INAC, OP_JPNZ,
            OP_JPZ, OP_NOP, OP_CLAC, OP_END: ok = 1'b1;
            default: begin
                if (op >= 6'd11 && op <= 6'd14)
                    ok = (int'(op) - 10) <= NUM_REGS;
                else if (op >= 6'd15 && op <= 6'd18)
                    ok = (int'(op) - 14) <= NUM_REGS;
            end
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            jmp_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            jmp_q   <= jmp_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = '0;
        jmp_d    = jmp_q;
        ill_d    = ill_q;
        alu_op   = '0;
        read_en  = '0;
        write_en = '0;
        inc_en   = '0;
        clr_en   = '0;
        busy     = (state_q != S_IDLE) && (state_q != S_HALT);
        done     = (state_q == S_HALT);

        case (state_q)
            S_IDLE: begin
                clr_en[1] = 1'b1;
                clr_en[4] = 1'b1;
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                read_en = 4'd13;
                if (cnt_q == LAST) begin
                    write_en[3] = 1'b1;
                    state_d     = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DECODE: begin
                op_d    = instr;
                state_d = S_EXEC1;
            end
            S_EXEC1: begin
                state_d = S_FETCH;
                if (!is_legal(op_q)) begin
                    // Trap leaves every strobe low so the PC stays on the bad opcode.
                    if (TRAP) begin
                        ill_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        inc_en[1] = 1'b1;
                    end
                end else begin
                    case (op_q)
                        OP_LDAC, OP_LDIAC: begin
                            read_en     = (op_q == OP_LDAC) ? 4'd5 : 4'd4;
                            write_en[2] = 1'b1;
                            state_d     = S_MWAIT;
                        end
                        OP_STAC: begin
                            read_en      = 4'd5;
                            write_en[11] = 1'b1;
                            state_d      = S_EXEC2;
                        end
                        OP_STIAC: begin
                            read_en     = 4'd4;
                            write_en[2] = 1'b1;
                            state_d     = S_EXEC2;
                        end
                        OP_MVAC, OP_MVACAR: begin
                            read_en = 4'd5;
                            if (op_q == OP_MVAC) write_en[5] = 1'b1;
                            else                 write_en[2] = 1'b1;
                            inc_en[1] = 1'b1;
                        end
                        6'd11, 6'd12, 6'd13, 6'd14: begin
                            read_en = 4'd5;
                            case (op_q)
                                6'd11:   write_en[10] = 1'b1;
                                6'd12:   write_en[9]  = 1'b1;
                                6'd13:   write_en[8]  = 1'b1;
                                default: write_en[7]  = 1'b1;
                            endcase
                            inc_en[1] = 1'b1;
                        end
                        6'd15, 6'd16, 6'd17, 6'd18: begin
                            read_en     = 4'(op_q - 6'd8);
                            write_en[4] = 1'b1;
                            inc_en[1]   = 1'b1;
                        end
                        OP_ADD, OP_MULT, OP_LSHIFT, OP_SUB: begin
                            case (op_q)
                                OP_ADD:  alu_op = 3'd1;
                                OP_SUB:  alu_op = 3'd2;
                                OP_MULT: alu_op = 3'd3;
                                default: alu_op = 3'd4;
                            endcase
                            write_en[12] = 1'b1;
                            state_d      = S_EXEC2;
                        end
                        OP_INAC: begin
                            inc_en[4] = 1'b1;
                            inc_en[1] = 1'b1;
                        end
                        OP_CLAC: begin
                            clr_en[4] = 1'b1;
                            inc_en[1] = 1'b1;
                        end
                        OP_JPNZ, OP_JPZ: begin
                            jmp_d   = (op_q == OP_JPZ) ? z : ~z;
                            state_d = S_EXEC2;
                        end
                        OP_END:  state_d = S_HALT;
                        default: inc_en[1] = 1'b1;
                    endcase
                end
            end
            S_EXEC2: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_STIAC: begin
                        read_en      = 4'd5;
                        write_en[11] = 1'b1;
                        state_d      = S_MWAIT;
                    end
                    OP_ADD, OP_MULT, OP_LSHIFT, OP_SUB: begin
                        write_en[12] = 1'b1;
                        inc_en[1]    = 1'b1;
                    end
                    OP_JPNZ, OP_JPZ: begin
                        if (jmp_q) begin
                            read_en     = 4'd4;
                            write_en[1] = 1'b1;
                        end else begin
                            inc_en[1] = 1'b1;
                        end
                    end
                    default: inc_en[1] = 1'b1;
                endcase
            end
            S_MWAIT: begin
                if (op_q == OP_STIAC) begin
                    inc_en[1] = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    read_en = 4'd12;
                    if (cnt_q == LAST) begin
                        write_en[4] = 1'b1;
                        inc_en[1]   = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    ill_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign illegal = ill_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: instruction table expanded into per-cycle expected outputs.
module tb_ctrl_seq;

    localparam int W  = 2;
    localparam int NR = 2;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst, start, z;
    logic [5:0]  instr;
    logic [2:0]  alu_op;
    logic [3:0]  read_en;
    logic [15:0] write_en, inc_en, clr_en;
    logic        busy, done, illegal;

    ctrl_seq #(.NUM_REGS(NR), .MEM_WAIT(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .z(z), .instr(instr),
        .alu_op(alu_op), .read_en(read_en), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .busy(busy), .done(done),
        .illegal(illegal)
    );

    typedef struct packed {
        logic [2:0]  alu;
        logic [3:0]  rd;
        logic [15:0] we;
        logic [15:0] inc;
        logic [15:0] clr;
    } cyc_t;

    typedef struct {
        logic [5:0]  op;
        logic        zin;
        logic        sb;
        int unsigned n;
        logic        mw;
        logic        halt;
        logic        ill;
        cyc_t        c1, c2, c3;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] instr;
        logic       zin;
        logic       start;
        cyc_t       o;
        logic       busy, done, ill;
    } rec_t;

    rec_t q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [15:0] PC = 16'h0002;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic cyc_t mk(input logic [2:0] a, input logic [3:0] r,
                                input logic [15:0] w, input logic [15:0] i,
                                input logic [15:0] c);
        cyc_t x;
        x.alu = a; x.rd = r; x.we = w; x.inc = i; x.clr = c;
        return x;
    endfunction

    function automatic vec_t ent(input logic [5:0] op, input logic zin, input logic sb,
                                 input int unsigned n, input logic mw, input logic halt,
                                 input logic ill, input cyc_t c1, input cyc_t c2, input cyc_t c3);
        vec_t v;
        v.op = op; v.zin = zin; v.sb = sb; v.n = n; v.mw = mw;
        v.halt = halt; v.ill = ill; v.c1 = c1; v.c2 = c2; v.c3 = c3;
        return v;
    endfunction

    function automatic rec_t rec(input string nm, input logic [5:0] op, input logic zin,
                                 input logic st, input cyc_t o, input logic b,
                                 input logic d, input logic il);
        rec_t r;
        r.name = nm; r.instr = op; r.zin = zin; r.start = st; r.o = o;
        r.busy = b; r.done = d; r.ill = il;
        return r;
    endfunction

    task automatic check(input rec_t r);
        checks++;
        if (alu_op !== r.o.alu || read_en !== r.o.rd || write_en !== r.o.we ||
            inc_en !== r.o.inc || clr_en !== r.o.clr || busy !== r.busy ||
            done !== r.done || illegal !== r.ill) begin
            errors++;
            $display("FAIL %s op=%0d got alu=%0d rd=%0d we=%h inc=%h clr=%h busy=%b done=%b ill=%b want alu=%0d rd=%0d we=%h inc=%h clr=%h busy=%b done=%b ill=%b",
                     r.name, r.instr, alu_op, read_en, write_en, inc_en, clr_en, busy, done, illegal,
                     r.o.alu, r.o.rd, r.o.we, r.o.inc, r.o.clr, r.busy, r.done, r.ill);
        end
    endtask

    task automatic push_idle(input logic [5:0] op, input logic st);
        q.push_back(rec("IDLE", op, 1'b0, st, mk(0, 0, 0, 0, 16'h0012), 0, 0, 0));
    endtask

    // Expands one table entry into the expected cycle-by-cycle output records.
    task automatic gen(input vec_t t);
        cyc_t zc;
        zc = mk(0, 0, 0, 0, 0);
        for (int i = 0; i <= W; i++)
            q.push_back(rec("FETCH", t.op, t.zin, t.sb,
                            mk(0, 13, (i == W) ? 16'h0008 : 16'h0000, 0, 0), 1, 0, 0));
        q.push_back(rec("DECODE", t.op, t.zin, t.sb, zc, 1, 0, 0));
        q.push_back(rec("EXEC1", t.op, t.zin, t.sb, t.c1, 1, 0, 0));
        if (t.mw) begin
            for (int i = 0; i < W; i++)
                q.push_back(rec("MWAIT", t.op, t.zin, t.sb, t.c2, 1, 0, 0));
            q.push_back(rec("MWAIT_LAST", t.op, t.zin, t.sb, t.c3, 1, 0, 0));
        end else begin
            if (t.n > 1) q.push_back(rec("EXEC2", t.op, t.zin, t.sb, t.c2, 1, 0, 0));
            if (t.n > 2) q.push_back(rec("EXEC3", t.op, t.zin, t.sb, t.c3, 1, 0, 0));
        end
        if (t.halt) begin
            q.push_back(rec("HALT", t.op, t.zin, 1'b0, zc, 0, 1, t.ill));
            q.push_back(rec("HALT_START", t.op, t.zin, 1'b1, zc, 0, 1, t.ill));
            push_idle(t.op, 1'b1);
        end
    endtask

    task automatic drain_n(input int unsigned n);
        rec_t r;
        for (int unsigned i = 0; i < n && q.size() > 0; i++) begin
            r = q.pop_front();
            @(negedge clk);
            instr = r.instr;
            z     = r.zin;
            start = r.start;
            check(r);
        end
    endtask

    initial begin
        cyc_t zc, nopc, illc;
        rec_t r;
        zc   = mk(0, 0, 0, 0, 0);
        nopc = mk(0, 0, 0, PC, 0);
        illc = TRAP ? zc : nopc;

        tbl.push_back(ent(6'd3,  0, 0, 1, 1, 0, 0, mk(0, 5, 16'h0004, 0, 0), mk(0, 12, 0, 0, 0), mk(0, 12, 16'h0010, PC, 0)));
        tbl.push_back(ent(6'd28, 0, 1, 1, 0, 0, 0, nopc, zc, zc));
        tbl.push_back(ent(6'd8,  0, 0, 2, 0, 0, 0, mk(0, 5, 16'h0800, 0, 0), nopc, zc));
        tbl.push_back(ent(6'd26, 0, 0, 3, 0, 0, 0, mk(0, 4, 16'h0004, 0, 0), mk(0, 5, 16'h0800, 0, 0), nopc));
        tbl.push_back(ent(6'd9,  0, 0, 1, 0, 0, 0, mk(0, 5, 16'h0020, PC, 0), zc, zc));
        tbl.push_back(ent(6'd10, 0, 0, 1, 0, 0, 0, mk(0, 5, 16'h0004, PC, 0), zc, zc));
        tbl.push_back(ent(6'd11, 0, 0, 1, 0, 0, 0, mk(0, 5, 16'h0400, PC, 0), zc, zc));
        tbl.push_back(ent(6'd12, 0, 0, 1, 0, 0, 0, mk(0, 5, 16'h0200, PC, 0), zc, zc));
        tbl.push_back(ent(6'd15, 0, 0, 1, 0, 0, 0, mk(0, 7, 16'h0010, PC, 0), zc, zc));
        tbl.push_back(ent(6'd16, 0, 0, 1, 0, 0, 0, mk(0, 8, 16'h0010, PC, 0), zc, zc));
        tbl.push_back(ent(6'd19, 0, 0, 2, 0, 0, 0, mk(1, 0, 16'h1000, 0, 0), mk(0, 0, 16'h1000, PC, 0), zc));
        tbl.push_back(ent(6'd20, 0, 0, 2, 0, 0, 0, mk(3, 0, 16'h1000, 0, 0), mk(0, 0, 16'h1000, PC, 0), zc));
        tbl.push_back(ent(6'd21, 0, 0, 2, 0, 0, 0, mk(4, 0, 16'h1000, 0, 0), mk(0, 0, 16'h1000, PC, 0), zc));
        tbl.push_back(ent(6'd22, 0, 0, 2, 0, 0, 0, mk(2, 0, 16'h1000, 0, 0), mk(0, 0, 16'h1000, PC, 0), zc));
        tbl.push_back(ent(6'd23, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 16'h0012, 0), zc, zc));
        tbl.push_back(ent(6'd30, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, PC, 16'h0010), zc, zc));
        tbl.push_back(ent(6'd24, 0, 0, 2, 0, 0, 0, zc, mk(0, 4, PC, 0, 0), zc));
        tbl.push_back(ent(6'd24, 1, 0, 2, 0, 0, 0, zc, nopc, zc));
        tbl.push_back(ent(6'd27, 0, 0, 2, 0, 0, 0, zc, nopc, zc));
        tbl.push_back(ent(6'd27, 1, 0, 2, 0, 0, 0, zc, mk(0, 4, PC, 0, 0), zc));
        tbl.push_back(ent(6'd5,  0, 0, 1, 1, 0, 0, mk(0, 4, 16'h0004, 0, 0), mk(0, 12, 0, 0, 0), mk(0, 12, 16'h0010, PC, 0)));
        tbl.push_back(ent(6'd13, 0, 0, 1, 0, TRAP, TRAP, illc, zc, zc));
        tbl.push_back(ent(6'd17, 0, 0, 1, 0, TRAP, TRAP, illc, zc, zc));
        tbl.push_back(ent(6'd0,  0, 0, 1, 0, TRAP, TRAP, illc, zc, zc));
        tbl.push_back(ent(6'd31, 0, 0, 1, 0, 1, 0, zc, zc, zc));
        tbl.push_back(ent(6'd28, 0, 0, 1, 0, 0, 0, nopc, zc, zc));

        rst = 1'b1; start = 1'b0; z = 1'b0; instr = '0;
        @(negedge clk);
        check(rec("RESET", 6'd0, 0, 0, mk(0, 0, 0, 0, 16'h0012), 0, 0, 0));
        #2 rst = 1'b0;

        push_idle(6'd0, 1'b1);
        foreach (tbl[i]) begin
            gen(tbl[i]);
            drain_n(q.size());
        end

        // STIAC interrupted by reset while its DM write strobe is up.
        gen(ent(6'd26, 0, 0, 3, 0, 0, 0, mk(0, 4, 16'h0004, 0, 0), mk(0, 5, 16'h0800, 0, 0), nopc));
        drain_n(W + 4);
        q.delete();
        #2 rst = 1'b1;
        #1 check(rec("RST_ASYNC", 6'd26, 0, 0, mk(0, 0, 0, 0, 16'h0012), 0, 0, 0));
        @(negedge clk);
        check(rec("RST_HELD", 6'd26, 0, 0, mk(0, 0, 0, 0, 16'h0012), 0, 0, 0));
        #1 rst = 1'b0;
        push_idle(6'd28, 1'b1);
        gen(ent(6'd28, 0, 0, 1, 0, 0, 0, nopc, zc, zc));
        gen(ent(6'd31, 0, 0, 1, 0, 1, 0, zc, zc, zc));
        drain_n(q.size());

        r = rec("FETCH_AFTER_RESTART", 6'd31, 0, 0, mk(0, 13, 0, 0, 0), 1, 0, 0);
        @(negedge clk);
        start = 1'b0;
        check(r);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
